// File: rtl/cpmath_pkg.sv
// Shared constants and state encoding for the calculator math/display path.
package cpmath_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   localparam int         BCD_DIGITS = 3;
   localparam int         MAX_MAG    = 999;
   localparam logic [3:0] ERR_DIGIT  = 4'hE;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: add 3 to any BCD nibble of 5 or more.
module bcd_add3 (
   input  logic [3:0] in_nib,
   output logic [3:0] out_nib
);

   assign out_nib = (in_nib >= 4'd5) ? (in_nib + 4'd3) : in_nib;

endmodule

// File: rtl/bcd_convert_ctrl.sv
// Sequential signed-binary to 3-digit BCD converter with held outputs for the
// seven-segment driver; one value in flight at a time.
module bcd_convert_ctrl
   import cpmath_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int SHIFT_STEPS = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [3:0]       digit0,
   output logic [3:0]       digit1,
   output logic [3:0]       digit2,
   output logic             out_neg,
   output logic             out_ovf,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int CNT_W  = $clog2(SHIFT_STEPS + 1);
   localparam int BCD_W  = 4 * BCD_DIGITS;
   localparam int WORK_W = BCD_W + SHIFT_STEPS;

   state_e                     state_q, state_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [WORK_W-1:0]          work_q, work_d;
   logic [BCD_DIGITS-1:0][3:0] digit_q, digit_d;
   logic                       neg_q, neg_d;
   logic                       ovf_q, ovf_d;

   logic                       in_neg;
   logic [WIDTH-1:0]           mag;
   logic [BCD_DIGITS-1:0][3:0] nib_adj;
   logic [WORK_W-1:0]          corr;
   logic [WORK_W-1:0]          shifted;

   assign in_neg = in_data[WIDTH-1];
   assign mag    = in_neg ? (~in_data + WIDTH'(1)) : in_data;

   for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_add3
      bcd_add3 u_add3 (
         .in_nib  (work_q[SHIFT_STEPS + 4*i +: 4]),
         .out_nib (nib_adj[i])
      );
   end

   assign corr    = {nib_adj, work_q[SHIFT_STEPS-1:0]};
   assign shifted = {corr[WORK_W-2:0], 1'b0};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
      digit_d = digit_q;
      neg_d   = neg_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready) begin
               neg_d = in_neg;
               if (mag > WIDTH'(MAX_MAG)) begin
                  ovf_d   = 1'b1;
                  digit_d = {BCD_DIGITS{ERR_DIGIT}};
                  state_d = ST_DONE;
               end else begin
                  work_d  = {{BCD_W{1'b0}}, mag[SHIFT_STEPS-1:0]};
                  cnt_d   = '0;
                  state_d = ST_SHIFT;
               end
            end
         end
         ST_SHIFT: begin
            work_d = shifted;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(SHIFT_STEPS - 1)) begin
               digit_d = shifted[WORK_W-1 -: BCD_W];
               // Bit shifted out of the hundreds nibble is always 0 for
               // magnitudes <= 999, so this clears the flag on a good result.
               ovf_d   = corr[WORK_W-1];
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         work_q  <= '0;
         digit_q <= '0;
         neg_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
         digit_q <= digit_d;
         neg_q   <= neg_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE) && !rst;
   assign out_valid = (state_q == ST_DONE);
   assign digit0    = digit_q[0];
   assign digit1    = digit_q[1];
   assign digit2    = digit_q[2];
   assign out_neg   = neg_q;
   assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_bcd_convert_ctrl.sv
// Directed and streaming checks for bcd_convert_ctrl.
module tb_bcd_convert_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  digit0, digit1, digit2;
   logic        out_neg, out_ovf, out_valid;
   logic        out_ready;

   int checks = 0;
   int errors = 0;

   bcd_convert_ctrl #(.WIDTH(32), .SHIFT_STEPS(10)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .digit0    (digit0),
      .digit1    (digit1),
      .digit2    (digit2),
      .out_neg   (out_neg),
      .out_ovf   (out_ovf),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   // Drive one value at a negedge once in_ready is up; returns at the negedge after acceptance.
   task automatic accept(input logic [31:0] v);
      int n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL accept_ready: in_ready=%b expected 1", in_ready);
      end
      in_valid = 1'b1;
      in_data  = v;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Edges after acceptance until out_valid is seen (bounded).
   task automatic wait_valid(output int edges);
      edges = 0;
      while (!out_valid && edges < 40) begin
         @(posedge clk);
         @(negedge clk);
         edges++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({in_ready, out_valid, out_neg, out_ovf} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: rdy/vld/neg/ovf=%b expected 0000", {in_ready, out_valid, out_neg, out_ovf});
      end
      checks++;
      if ({digit2, digit1, digit0} !== 12'h000) begin
         errors++;
         $display("FAIL reset_digits: got %h expected 000", {digit2, digit1, digit0});
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: got %b expected 1", in_ready);
      end
   endtask

   task automatic test_convert_123();
      int e;
      out_ready = 1'b1;
      accept(32'd123);
      wait_valid(e);
      checks++;
      if (e !== 10) begin
         errors++;
         $display("FAIL lat_123: got %0d edges expected 10", e);
      end
      checks++;
      if ({digit2, digit1, digit0, out_neg, out_ovf} !== {12'h123, 2'b00}) begin
         errors++;
         $display("FAIL res_123: got %h neg=%b ovf=%b expected 123 neg=0 ovf=0", {digit2, digit1, digit0}, out_neg, out_ovf);
      end
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL ready_in_done: got %b expected 0", in_ready);
      end
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         errors++;
         $display("FAIL ready_after_hs: rdy/vld=%b expected 10", {in_ready, out_valid});
      end
   endtask

   task automatic test_sign_zero();
      int e;
      accept(32'hFFFF_FFD3);
      wait_valid(e);
      checks++;
      if ({digit2, digit1, digit0, out_neg, out_ovf} !== {12'h045, 2'b10}) begin
         errors++;
         $display("FAIL res_m45: got %h neg=%b ovf=%b expected 045 neg=1 ovf=0", {digit2, digit1, digit0}, out_neg, out_ovf);
      end
      @(negedge clk);
      accept(32'd0);
      wait_valid(e);
      checks++;
      if ({digit2, digit1, digit0, out_neg, out_ovf} !== {12'h000, 2'b00}) begin
         errors++;
         $display("FAIL res_zero: got %h neg=%b ovf=%b expected 000 neg=0 ovf=0", {digit2, digit1, digit0}, out_neg, out_ovf);
      end
      @(negedge clk);
   endtask

   task automatic test_boundaries();
      int e;
      accept(32'd999);
      wait_valid(e);
      checks++;
      if ({digit2, digit1, digit0, out_neg, out_ovf} !== {12'h999, 2'b00}) begin
         errors++;
         $display("FAIL res_999: got %h neg=%b ovf=%b expected 999 neg=0 ovf=0", {digit2, digit1, digit0}, out_neg, out_ovf);
      end
      @(negedge clk);
      accept(32'd1000);
      wait_valid(e);
      checks++;
      if (e !== 0) begin
         errors++;
         $display("FAIL lat_ovf: got %0d edges expected 0", e);
      end
      checks++;
      if ({digit2, digit1, digit0, out_neg, out_ovf} !== {12'hEEE, 2'b01}) begin
         errors++;
         $display("FAIL res_1000: got %h neg=%b ovf=%b expected EEE neg=0 ovf=1", {digit2, digit1, digit0}, out_neg, out_ovf);
      end
      @(negedge clk);
      accept(32'h8000_0000);
      wait_valid(e);
      checks++;
      if ({digit2, digit1, digit0, out_neg, out_ovf, e} !== {12'hEEE, 2'b11, 32'd0}) begin
         errors++;
         $display("FAIL res_min: got %h neg=%b ovf=%b edges=%0d expected EEE neg=1 ovf=1 edges=0", {digit2, digit1, digit0}, out_neg, out_ovf, e);
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      int e;
      int bad = 0;
      out_ready = 1'b0;
      accept(32'd321);
      wait_valid(e);
      for (int k = 0; k < 20; k++) begin
         in_valid = 1'b1;
         in_data  = 32'd5;
         @(posedge clk);
         @(negedge clk);
         checks++;
         if ({out_valid, in_ready, digit2, digit1, digit0, out_neg, out_ovf} !== {2'b10, 12'h321, 2'b00}) begin
            errors++;
            bad++;
            if (bad < 4)
               $display("FAIL bp_hold[%0d]: vld/rdy=%b dig=%h neg=%b ovf=%b expected 10 321 0 0", k, {out_valid, in_ready}, {digit2, digit1, digit0}, out_neg, out_ovf);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         errors++;
         $display("FAIL bp_release: vld/rdy=%b expected 01", {out_valid, in_ready});
      end
      @(negedge clk);
      checks++;
      if ({out_valid, digit2, digit1, digit0} !== {1'b0, 12'h321}) begin
         errors++;
         $display("FAIL bp_single_hs: vld=%b dig=%h expected 0 321", out_valid, {digit2, digit1, digit0});
      end
   endtask

   task automatic test_reset_mid();
      int e;
      int seen = 0;
      accept(32'd777);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (out_valid) seen++;
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, digit2, digit1, digit0, out_neg, out_ovf} !== 16'h0000) begin
         errors++;
         $display("FAIL rst_mid_outputs: vld/rdy=%b dig=%h neg=%b ovf=%b expected all 0", {out_valid, in_ready}, {digit2, digit1, digit0}, out_neg, out_ovf);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_ready: got %b expected 1", in_ready);
      end
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL rst_mid_no_valid: saw %0d valid cycles expected 0", seen);
      end
      accept(32'd42);
      wait_valid(e);
      checks++;
      if ({digit2, digit1, digit0, out_neg, out_ovf, e} !== {12'h042, 2'b00, 32'd10}) begin
         errors++;
         $display("FAIL res_42: got %h neg=%b ovf=%b edges=%0d expected 042 0 0 10", {digit2, digit1, digit0}, out_neg, out_ovf, e);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int          q[$];
      int          done_cnt = 0;
      int          cyc = 0;
      int          v, m;
      logic        accepted, prev_vld;
      logic [11:0] prev_dig, exp_dig;
      logic        exp_neg, exp_ovf;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'(int'($urandom_range(4000)) - 2000);
      prev_vld  = out_valid;
      prev_dig  = {digit2, digit1, digit0};
      while (done_cnt < 30 && cyc < 2000) begin
         accepted = in_ready;
         if (accepted) q.push_back(int'(in_data));
         @(posedge clk);
         @(negedge clk);
         cyc++;
         if (accepted) in_data = 32'(int'($urandom_range(4000)) - 2000);
         checks++;
         if ({digit2, digit1, digit0} !== prev_dig && !(out_valid && !prev_vld)) begin
            errors++;
            $display("FAIL b2b_digit_glitch: dig %h -> %h without valid rise", prev_dig, {digit2, digit1, digit0});
         end
         if (out_valid && !prev_vld) begin
            v       = (q.size() > 0) ? q.pop_front() : 0;
            exp_neg = (v < 0);
            m       = exp_neg ? -v : v;
            exp_ovf = (m > 999);
            if (exp_ovf) exp_dig = 12'hEEE;
            else exp_dig = {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
            checks++;
            if ({digit2, digit1, digit0, out_neg, out_ovf} !== {exp_dig, exp_neg, exp_ovf}) begin
               errors++;
               $display("FAIL b2b_result(%0d): got %h neg=%b ovf=%b expected %h neg=%b ovf=%b", v, {digit2, digit1, digit0}, out_neg, out_ovf, exp_dig, exp_neg, exp_ovf);
            end
            done_cnt++;
         end
         prev_vld = out_valid;
         prev_dig = {digit2, digit1, digit0};
      end
      checks++;
      if (done_cnt !== 30) begin
         errors++;
         $display("FAIL b2b_count: got %0d results expected 30", done_cnt);
      end
      in_valid = 1'b0;
      repeat (15) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_convert_123();
      test_sign_zero();
      test_boundaries();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
